// File: rtl/thread_dispatch_resp.sv
// Dispatcher-side responder for fork/stop thread messages: scans a table of
// live threads one slot per cycle and returns a DONE code plus result word.
`ifndef CPU_MSG_SIZE
`define CPU_MSG_SIZE 4
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef CPU_R_FORK_THRD
`define CPU_R_FORK_THRD 1
`endif
`ifndef CPU_R_STOP_THRD
`define CPU_R_STOP_THRD 2
`endif
`ifndef CPU_R_FORK_DONE
`define CPU_R_FORK_DONE 3
`endif
`ifndef CPU_R_STOP_DONE
`define CPU_R_STOP_DONE 4
`endif

module thread_dispatch_resp #(
  parameter int THREADS = 8,
  parameter int IDX_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_oe,
  input  logic [`CPU_MSG_SIZE-1:0] cpu_msg_in,
  input  logic                     msg_pulse_in,
  input  logic [`ADDR_SIZE-1:0]    addr_in,
  input  logic [`DATA_SIZE-1:0]    data_in,
  input  logic                     is_bus_busy,
  output logic                     disp_online,
  output logic [`CPU_MSG_SIZE-1:0] cpu_msg_out,
  output logic [`DATA_SIZE-1:0]    data_out,
  output logic [IDX_W:0]           thread_cnt
);
  localparam logic [`CPU_MSG_SIZE-1:0] C_FORK      = `CPU_MSG_SIZE'(`CPU_R_FORK_THRD);
  localparam logic [`CPU_MSG_SIZE-1:0] C_STOP      = `CPU_MSG_SIZE'(`CPU_R_STOP_THRD);
  localparam logic [`CPU_MSG_SIZE-1:0] C_FORK_DONE = `CPU_MSG_SIZE'(`CPU_R_FORK_DONE);
  localparam logic [`CPU_MSG_SIZE-1:0] C_STOP_DONE = `CPU_MSG_SIZE'(`CPU_R_STOP_DONE);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;
  state_t r_state, w_state_next;

  logic [THREADS-1:0]       r_valid;
  logic [`ADDR_SIZE-1:0]    r_entry_addr [THREADS];
  logic [`DATA_SIZE-1:0]    r_data_base  [THREADS];
  logic [`CPU_MSG_SIZE-1:0] r_code;
  logic [`ADDR_SIZE-1:0]    r_addr;
  logic [`DATA_SIZE-1:0]    r_data;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_found;
  logic [IDX_W-1:0]         r_found_idx;
  logic [IDX_W:0]           r_cnt;
  logic [`CPU_MSG_SIZE-1:0] r_msg_out;
  logic [`DATA_SIZE-1:0]    r_data_out;

  logic w_accept, w_is_fork, w_slot_hit, w_last, w_fire;

  assign w_accept   = msg_pulse_in && (cpu_msg_in == C_FORK || cpu_msg_in == C_STOP);
  assign w_is_fork  = (r_code == C_FORK);
  // Fork wants the lowest free slot; stop wants the lowest live slot with a matching address.
  assign w_slot_hit = w_is_fork ? !r_valid[r_idx]
                                : (r_valid[r_idx] && r_entry_addr[r_idx] == r_addr);
  assign w_last     = (r_idx == IDX_W'(THREADS - 1));
  assign w_fire     = (r_state == S_RESP) && !is_bus_busy;

  always_ff @(posedge clk) begin
    if (clk_oe) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_SCAN;
      S_SCAN:  if (w_last) w_state_next = S_RESP;
      S_RESP:  if (!is_bus_busy) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk_oe) begin
      if (!rst) begin
        r_valid     <= '0;
        r_cnt       <= '0;
        r_msg_out   <= '0;
        r_data_out  <= '0;
        r_found     <= 1'b0;
        r_found_idx <= '0;
        r_idx       <= '0;
        r_code      <= '0;
        r_addr      <= '0;
        r_data      <= '0;
      end else begin
        r_msg_out  <= '0;
        r_data_out <= '0;
        if (r_state == S_IDLE && w_accept) begin
          r_code  <= cpu_msg_in;
          r_addr  <= addr_in;
          r_data  <= data_in;
          r_idx   <= '0;
          r_found <= 1'b0;
        end
        if (r_state == S_SCAN) begin
          r_idx <= r_idx + IDX_W'(1);
          if (w_slot_hit && !r_found) begin
            r_found     <= 1'b1;
            r_found_idx <= r_idx;
          end
        end
        // The table update lands on the same edge as the DONE pulse.
        if (w_fire) begin
          if (w_is_fork) begin
            r_msg_out <= C_FORK_DONE;
            if (r_found) begin
              r_valid[r_found_idx]      <= 1'b1;
              r_entry_addr[r_found_idx] <= r_addr;
              r_data_base[r_found_idx]  <= r_data;
              r_cnt                     <= r_cnt + 1'b1;
              r_data_out                <= `DATA_SIZE'(r_found_idx);
            end else begin
              r_data_out <= '1;
            end
          end else begin
            r_msg_out <= C_STOP_DONE;
            if (r_found) begin
              r_valid[r_found_idx] <= 1'b0;
              r_cnt                <= r_cnt - 1'b1;
              r_data_out           <= r_data_base[r_found_idx];
            end else begin
              r_data_out <= '1;
            end
          end
        end
      end
    end
  end

  assign disp_online = (r_state == S_IDLE);
  assign cpu_msg_out = r_msg_out;
  assign data_out    = r_data_out;
  assign thread_cnt  = r_cnt;
endmodule

// File: tb/tb_thread_dispatch_resp.sv
// Bench for thread_dispatch_resp: directed vector table, hand sequences for
// reset/drop corner cases, then random requests against a slot-table model.
`timescale 1ns/1ps
`ifndef CPU_MSG_SIZE
`define CPU_MSG_SIZE 4
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module tb_thread_dispatch_resp;
  localparam logic [3:0] FORK = 4'd1, STOP = 4'd2, FORK_DONE = 4'd3, STOP_DONE = 4'd4;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk = 0, rst = 0, clk_oe = 1, msg_pulse_in = 0, is_bus_busy = 0;
  logic [3:0]  cpu_msg_in = 0;
  logic [31:0] addr_in = 0, data_in = 0;
  logic        disp_online;
  logic [3:0]  cpu_msg_out;
  logic [31:0] data_out;
  logic [3:0]  thread_cnt;

  int checks = 0, errors = 0;

  thread_dispatch_resp #(.THREADS(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe), .cpu_msg_in(cpu_msg_in),
    .msg_pulse_in(msg_pulse_in), .addr_in(addr_in), .data_in(data_in),
    .is_bus_busy(is_bus_busy), .disp_online(disp_online),
    .cpu_msg_out(cpu_msg_out), .data_out(data_out), .thread_cnt(thread_cnt));

  always #5 clk = ~clk;

  // Reference model: the thread table as plain arrays.
  bit          m_valid [8];
  logic [31:0] m_addr  [8];
  logic [31:0] m_data  [8];
  int          m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 0;
    m_cnt = 0;
  endtask

  task automatic model_req(input logic [3:0] code, input logic [31:0] a, input logic [31:0] d,
                           output logic [3:0] e_code, output logic [31:0] e_data);
    int slot = -1;
    for (int i = 7; i >= 0; i--)
      if (code == FORK ? !m_valid[i] : (m_valid[i] && m_addr[i] == a)) slot = i;
    e_code = (code == FORK) ? FORK_DONE : STOP_DONE;
    e_data = ONES;
    if (slot >= 0) begin
      if (code == FORK) begin
        m_valid[slot] = 1; m_addr[slot] = a; m_data[slot] = d; m_cnt++;
        e_data = 32'(slot);
      end else begin
        m_valid[slot] = 0; m_cnt--;
        e_data = m_data[slot];
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request; bus is busy for `busy` RESP cycles, clk_oe low for `oe_low` scan cycles.
  // With inject=1 a second request is pulsed mid-scan and must be dropped.
  task automatic do_req(input logic [3:0] code, input logic [31:0] a, input logic [31:0] d,
                        input int busy, input int oe_low, input bit inject,
                        output logic [3:0] g_code, output logic [31:0] g_data, output int lat);
    @(negedge clk);
    cpu_msg_in = code; addr_in = a; data_in = d; msg_pulse_in = 1;
    @(posedge clk); #1;
    msg_pulse_in = 0; cpu_msg_in = 0;
    lat = 0; g_code = 0; g_data = 0;
    for (int k = 1; k <= 60; k++) begin
      clk_oe      = !(k >= 3 && k < 3 + oe_low);
      is_bus_busy = (k <= 8 + oe_low + busy);
      if (inject && k == 3) begin msg_pulse_in = 1; cpu_msg_in = STOP; addr_in = a; end
      @(posedge clk); #1;
      msg_pulse_in = 0; cpu_msg_in = 0;
      if (k == 2) chk("online_in_scan", disp_online, 0);
      if (cpu_msg_out != 0) begin
        g_code = cpu_msg_out; g_data = data_out; lat = k;
        break;
      end
    end
    clk_oe = 1; is_bus_busy = 0;
    if (lat == 0) chk("resp_timeout", 0, 1);
    chk("online_after_done", disp_online, 1);
    @(posedge clk); #1;
    chk("pulse_len_code", cpu_msg_out, 0);
    chk("pulse_len_data", data_out, 0);
  endtask

  task automatic no_resp(input int cycles);
    bit seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (cpu_msg_out != 0 || data_out != 0) seen = 1;
    end
    chk("no_response", seen, 0);
  endtask

  typedef struct {
    logic [3:0]  code;
    logic [31:0] addr;
    logic [31:0] data;
    int          busy;
    int          oe_low;
    logic [3:0]  e_code;
    logic [31:0] e_data;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [3:0]  g_code, e_code;
    logic [31:0] g_data, e_data;
    int          lat;

    for (int i = 0; i < 8; i++)
      vecs.push_back('{FORK, (i == 0) ? 32'h100 : 32'h200 + 32'(4 * i), 32'h2000 + 32'(i * 'h100),
                       0, 0, FORK_DONE, 32'(i), i + 1});
    vecs.push_back('{FORK, 32'h300, 32'h7777, 5, 0, FORK_DONE, ONES, 8});
    vecs.push_back('{STOP, 32'h100, 32'h0,    0, 3, STOP_DONE, 32'h2000, 7});
    vecs.push_back('{FORK, 32'h400, 32'h5555, 0, 0, FORK_DONE, 32'h0, 8});
    vecs.push_back('{STOP, 32'h999, 32'h0,    1, 0, STOP_DONE, ONES, 8});
    vecs.push_back('{STOP, 32'h208, 32'h0,    2, 2, STOP_DONE, 32'h2200, 7});

    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_msg", cpu_msg_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_cnt", thread_cnt, 0);
    chk("rst_online", disp_online, 1);
    @(negedge clk); rst = 1;
    model_reset();

    foreach (vecs[i]) begin
      do_req(vecs[i].code, vecs[i].addr, vecs[i].data, vecs[i].busy, vecs[i].oe_low, 0,
             g_code, g_data, lat);
      model_req(vecs[i].code, vecs[i].addr, vecs[i].data, e_code, e_data);
      $display("vec %0d code=%0d addr=0x%0h -> code=%0d data=0x%0h lat=%0d cnt=%0d",
               i, vecs[i].code, vecs[i].addr, g_code, g_data, lat, thread_cnt);
      chk("vec_code", g_code, vecs[i].e_code);
      chk("vec_data", g_data, vecs[i].e_data);
      chk("vec_lat", lat, 9 + vecs[i].busy + vecs[i].oe_low);
      chk("vec_cnt", thread_cnt, vecs[i].e_cnt);
    end

    // Reset during a FORK scan: request aborted, table cleared.
    @(negedge clk);
    cpu_msg_in = FORK; addr_in = 32'h500; data_in = 32'h1; msg_pulse_in = 1;
    @(negedge clk); msg_pulse_in = 0; cpu_msg_in = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    model_reset();
    no_resp(15);
    chk("midscan_rst_cnt", thread_cnt, 0);
    chk("midscan_rst_online", disp_online, 1);
    $display("reset mid-scan: cnt=%0d online=%0d", thread_cnt, disp_online);

    // Second request pulsed while scanning must be dropped.
    do_req(FORK, 32'h100, 32'hABCD, 0, 0, 1, g_code, g_data, lat);
    model_req(FORK, 32'h100, 32'hABCD, e_code, e_data);
    $display("drop test: code=%0d data=0x%0h lat=%0d", g_code, g_data, lat);
    chk("drop_code", g_code, e_code);
    chk("drop_data", g_data, e_data);
    no_resp(15);
    chk("drop_cnt", thread_cnt, 1);

    // Unsupported code in IDLE is ignored.
    @(negedge clk);
    cpu_msg_in = 4'd7; msg_pulse_in = 1;
    @(negedge clk); msg_pulse_in = 0; cpu_msg_in = 0;
    chk("bad_code_online", disp_online, 1);
    no_resp(12);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] pool [4];
      int          r;
      logic [3:0]  code;
      logic [31:0] a, d;
      pool[0] = 32'h0; pool[1] = 32'h100; pool[2] = 32'h104; pool[3] = 32'h108;
      r = $urandom_range(0, 9);
      code = (r < 5) ? FORK : STOP;
      a = pool[$urandom_range(0, 3)];
      d = $urandom;
      if (r == 9) begin
        @(negedge clk);
        cpu_msg_in = 4'(r); msg_pulse_in = 1;
        @(negedge clk); msg_pulse_in = 0; cpu_msg_in = 0;
        no_resp(12);
        $display("rand %0d invalid code ignored cnt=%0d", n, thread_cnt);
      end else begin
        int busy, oe_low;
        busy = $urandom_range(0, 3);
        oe_low = $urandom_range(0, 2);
        do_req(code, a, d, busy, oe_low, 0, g_code, g_data, lat);
        model_req(code, a, d, e_code, e_data);
        $display("rand %0d code=%0d addr=0x%0h -> code=%0d data=0x%0h lat=%0d cnt=%0d",
                 n, code, a, g_code, g_data, lat, thread_cnt);
        chk("rand_code", g_code, e_code);
        chk("rand_data", g_data, e_data);
        chk("rand_lat", lat, 9 + busy + oe_low);
      end
      chk("rand_cnt", thread_cnt, m_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
